// File: rtl/frequency_meter.sv
// -----------------------------------------------------------------------------
// frequency_meter
//
// Gated edge counter. Counts synchronized rising edges of sig_in over a fixed
// window of 2**G system clocks and publishes the total with a one-cycle strobe.
// Windows run back-to-back with no dead cycle while enable stays high, so
// feeding it the output of an N-bit phase-accumulator DCO with G = N reads the
// DCO increment straight out of count.
//
// Parameters
//   G        window exponent, window length = 2**G clk cycles
//   W        width of count (default G+1, which never saturates for inputs
//            at or below clk/2)
//
// Ports
//   clk      system clock, all state updates on the rising edge
//   reset    asynchronous active-high reset, clears everything immediately
//   enable   level; high runs back-to-back windows, low stops/aborts
//   sig_in   asynchronous signal being measured
//   count    rising-edge count of the last completed window
//   valid    one-cycle pulse when count/overflow have just been updated
//   busy     high while a window is in progress
//   overflow last completed window saturated count
// -----------------------------------------------------------------------------
module frequency_meter #(
    parameter int G = 5,
    parameter int W = G + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         sig_in,
    output logic [W-1:0] count,
    output logic         valid,
    output logic         busy,
    output logic         overflow
);

    localparam logic [G-1:0] GATE_LAST = '1;
    localparam logic [W-1:0] EDGE_MAX  = '1;

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    state_t         state;
    logic           s1;
    logic           s2;
    logic           s3;
    logic           rise;
    logic [G-1:0]   gate_cnt;
    logic [W-1:0]   edge_cnt;
    logic           sat;
    logic           edge_full;
    logic [W-1:0]   edge_next;
    logic           sat_now;

    // Two flops bring sig_in into the clk domain; the third flop holds the
    // previous synchronized value so a 0->1 step can be seen. These run in
    // every state so the edge history is already settled when a window opens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating next value of the edge counter. A rise that arrives while
    // the counter is already full is not lost silently: it raises sat_now,
    // which feeds the sticky overflow flag.
    always_comb begin
        edge_full = (edge_cnt == EDGE_MAX);
        edge_next = edge_cnt;
        sat_now   = 1'b0;
        if (rise) begin
            if (edge_full) begin
                sat_now = 1'b1;
            end else begin
                edge_next = edge_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == GATE);

    // Window controller. On the final edge of a window the result is taken
    // from edge_next rather than edge_cnt, so a rise landing on that edge is
    // credited to the finishing window, while the working counters restart
    // at zero so a rise on the following edge goes to the new window. Dropping
    // enable at any edge, including the final one, abandons the window and
    // leaves the published result alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        if (gate_cnt == GATE_LAST) begin
                            count    <= edge_next;
                            overflow <= sat | sat_now;
                            valid    <= 1'b1;
                            edge_cnt <= '0;
                            sat      <= 1'b0;
                        end else begin
                            edge_cnt <= edge_next;
                            sat      <= sat | sat_now;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
// -----------------------------------------------------------------------------
// tb_frequency_meter
//
// Directed bench for frequency_meter. Two instances share every input: the
// default G=5/W=6 part and a G=5/W=3 part that saturates at full input rate.
// sig_in is produced by a separate driver process whose behaviour is chosen
// by sig_mode: static level, 40 ns period (DCO with p=8), toggle every clock,
// or single-cycle pulses scheduled so their detection lands on chosen edges.
// -----------------------------------------------------------------------------
module tb_frequency_meter;

    localparam int G      = 5;
    localparam int WINDOW = 1 << G;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sig_in;
    logic [5:0] count;
    logic       valid;
    logic       busy;
    logic       overflow;
    logic [2:0] count3;
    logic       valid3;
    logic       busy3;
    logic       overflow3;

    int tests_run;
    int tests_failed;
    int cyc;
    int sig_mode;
    logic sig_level;
    int tgt [6];

    frequency_meter #(.G(G)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
        .count    (count),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    frequency_meter #(.G(G), .W(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sig_in   (sig_in),
        .count    (count3),
        .valid    (valid3),
        .busy     (busy3),
        .overflow (overflow3)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge index: after the k-th rising edge cyc == k.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic bit hit(input int k);
        for (int i = 0; i < 6; i++) begin
            if (tgt[i] == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    // sig_in driver, updated 2 ns after each rising edge. In pulse mode a
    // one-cycle pulse launched after edge k is detected by the DUT on edge
    // k+3 (two synchronizer stages plus the edge-history flop).
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (sig_mode)
                0:       sig_in = sig_level;
                1:       sig_in = ((cyc / 2) % 2) == 1;
                2:       sig_in = ~sig_in;
                default: sig_in = hit(cyc + 3);
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input int mode, input logic lvl);
        @(negedge clk);
        enable    = en;
        sig_mode  = mode;
        sig_level = lvl;
    endtask

    // Waits on falling edges until valid is seen or the budget runs out.
    task automatic waitValid(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!valid && waited < limit);
        checkOutput("valid_seen", valid, 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int waited;
        int fp;
        int total;
        int expect_cnt [5];
        bit seen;

        tests_run    = 0;
        tests_failed = 0;
        sig_mode     = 0;
        sig_level    = 1'b0;
        enable       = 1'b0;
        reset        = 1'b1;
        for (int i = 0; i < 6; i++) tgt[i] = -100;

        // Reset state.
        idleCycles(3);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        idleCycles(3);
        checkOutput("idle_busy", busy, 0);

        // DCO input, 40 ns period -> 8 edges per 32-cycle window.
        applyStimulus(1'b1, 1, 1'b0);
        @(negedge clk);
        checkOutput("dco_busy", busy, 1);
        waitValid(40, waited);
        checkOutput("dco_first_in_range", (count >= 7 && count <= 9), 1);
        for (int w = 0; w < 2; w++) begin
            waitValid(40, waited);
            checkOutput("dco_interval", waited, WINDOW);
            checkOutput("dco_count", count, 8);
            checkOutput("dco_overflow", overflow, 0);
        end

        // Abort 10 cycles into the next window.
        idleCycles(9);
        applyStimulus(1'b0, 0, 1'b0);
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        checkOutput("abort_no_valid", seen, 0);
        checkOutput("abort_count_held", count, 8);

        // Static low, then static high, three windows each.
        applyStimulus(1'b1, 0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            waitValid(40, waited);
            checkOutput("static0_count", count, 0);
            checkOutput("static0_overflow", overflow, 0);
        end
        applyStimulus(1'b0, 0, 1'b1);
        idleCycles(6);
        applyStimulus(1'b1, 0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            waitValid(40, waited);
            checkOutput("static1_count", count, 0);
            checkOutput("static1_overflow", overflow, 0);
        end
        applyStimulus(1'b0, 0, 1'b1);
        idleCycles(6);

        // Maximum rate: toggle every clock -> 16 edges per window.
        applyStimulus(1'b1, 2, 1'b0);
        @(negedge clk);
        checkOutput("max_busy3", busy3, 1);
        waitValid(40, waited);
        for (int w = 0; w < 2; w++) begin
            waitValid(40, waited);
            checkOutput("max_count", count, 16);
            checkOutput("max_overflow", overflow, 0);
            checkOutput("max_valid3", valid3, 1);
            checkOutput("max_count_w3", count3, 7);
            checkOutput("max_overflow_w3", overflow3, 1);
        end
        applyStimulus(1'b0, 3, 1'b0);
        idleCycles(6);

        // Window boundary: detections on first and final edges of windows.
        applyStimulus(1'b1, 3, 1'b0);
        waitValid(40, waited);
        fp = cyc;
        tgt[0] = fp + 33;
        tgt[1] = fp + 64;
        tgt[2] = fp + 80;
        tgt[3] = fp + 97;
        tgt[4] = fp + 128;
        tgt[5] = fp + 144;
        expect_cnt = '{0, 2, 1, 2, 1};
        total = 0;
        for (int w = 0; w < 5; w++) begin
            waitValid(40, waited);
            checkOutput("boundary_interval", waited, WINDOW);
            checkOutput("boundary_count", count, expect_cnt[w]);
            total += int'(count);
        end
        checkOutput("boundary_total", total, 6);

        // Asynchronous reset in the middle of a window.
        idleCycles(10);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", valid, 0);
        checkOutput("midrst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        waitValid(60, waited);
        checkOutput("midrst_first_valid", waited, WINDOW + 1);
        checkOutput("midrst_count_after", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
